// File: rtl/fetch_buffer_pkg.sv
// Shared RV32I field positions and opcode constants for the front end.
// Decode and the future issue logic reuse the same helpers.
package fetch_buffer_pkg;

  localparam int INST_W  = 32;
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;
  typedef logic [RD_MSB-RD_LSB:0]   reg_idx_t;

  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_OP_IMM = 7'b0010011;
  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;

  function automatic logic is_ctrl_xfer(input opcode_t op);
    return (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
  endfunction

  function automatic logic writes_rd(input opcode_t op);
    return (op != OPC_STORE) && (op != OPC_BRANCH);
  endfunction

  function automatic logic reads_rs1(input opcode_t op);
    return (op != OPC_LUI) && (op != OPC_AUIPC) && (op != OPC_JAL);
  endfunction

  function automatic logic reads_rs2(input opcode_t op);
    return (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
  endfunction

  // Decode will use this to flag illegal opcodes.
  function automatic logic is_base_opcode(input opcode_t op);
    return op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
  endfunction

endpackage

// File: rtl/fetch_buffer_dep_check.sv
// Pair-issue interlock: asserts o_hold when the second instruction of a pair
// must wait, either on a RAW hazard or because the first one redirects flow.
module dep_check
  import fetch_buffer_pkg::*;
(
  input  logic [INST_W-1:0] i_inst1,
  input  logic [INST_W-1:0] i_inst2,
  output logic              o_hold
);

  opcode_t  w_op1;
  opcode_t  w_op2;
  reg_idx_t w_rd1;
  reg_idx_t w_rs1_2;
  reg_idx_t w_rs2_2;
  logic     w_raw;
  logic     w_unused_bits;

  assign w_op1   = i_inst1[OPC_MSB:OPC_LSB];
  assign w_op2   = i_inst2[OPC_MSB:OPC_LSB];
  assign w_rd1   = i_inst1[RD_MSB:RD_LSB];
  assign w_rs1_2 = i_inst2[RS1_MSB:RS1_LSB];
  assign w_rs2_2 = i_inst2[RS2_MSB:RS2_LSB];

  // x0 is hardwired zero, so writing it never creates a hazard.
  assign w_raw = writes_rd(w_op1) && (w_rd1 != '0) &&
                 ((reads_rs1(w_op2) && (w_rs1_2 == w_rd1)) ||
                  (reads_rs2(w_op2) && (w_rs2_2 == w_rd1)));

  assign o_hold = is_ctrl_xfer(w_op1) || w_raw;

  assign w_unused_bits = ^{i_inst1[INST_W-1:RD_MSB+1], i_inst2[INST_W-1:RS2_MSB+1],
                           i_inst2[RS1_LSB-1:RD_LSB]};

endmodule

// File: rtl/fetch_buffer.sv
// Dual-entry instruction buffer between fetch and decode: circular store of
// {pc, inst}, in-order issue of up to two per cycle with pair interlock.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 13
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              f_valid,
  input  logic [PC_W-1:0]   f_pc1,
  input  logic [PC_W-1:0]   f_pc2,
  input  logic [INST_W-1:0] f_inst1,
  input  logic [INST_W-1:0] f_inst2,
  output logic              stall,
  input  logic              flush,
  input  logic              d_ready,
  output logic              i_valid1,
  output logic              i_valid2,
  output logic [PC_W-1:0]   i_pc1,
  output logic [PC_W-1:0]   i_pc2,
  output logic [INST_W-1:0] i_inst1,
  output logic [INST_W-1:0] i_inst2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]  w_head_nxt_slot;
  logic [PTR_W-1:0]  w_tail_nxt_slot;
  logic              w_push;
  logic              w_hold;
  logic [CNT_W-1:0]  w_push_n;
  logic [CNT_W-1:0]  w_pop_n;

  // Pointer widths equal log2(DEPTH), so +1 wraps modulo DEPTH by itself.
  assign w_head_nxt_slot = r_head + PTR_W'(1);
  assign w_tail_nxt_slot = r_tail + PTR_W'(1);

  assign stall  = (r_count > CNT_W'(DEPTH - 2));
  assign w_push = f_valid && !stall && !flush;

  assign i_pc1   = r_pc_mem[r_head];
  assign i_inst1 = r_inst_mem[r_head];
  assign i_pc2   = r_pc_mem[w_head_nxt_slot];
  assign i_inst2 = r_inst_mem[w_head_nxt_slot];

  dep_check u_dep_check (
    .i_inst1 (i_inst1),
    .i_inst2 (i_inst2),
    .o_hold  (w_hold)
  );

  assign i_valid1 = (r_count != '0) && !flush;
  assign i_valid2 = (r_count >= CNT_W'(2)) && !flush && !w_hold;

  assign w_push_n = w_push ? CNT_W'(2) : '0;
  assign w_pop_n  = d_ready ? (CNT_W'(i_valid1) + CNT_W'(i_valid2)) : '0;

  // NOTE: entry storage has no reset; contents are only read behind a
  // non-zero count, so resetting the array would buy nothing.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_pc_mem[r_tail]            <= f_pc1;
      r_inst_mem[r_tail]          <= f_inst1;
      r_pc_mem[w_tail_nxt_slot]   <= f_pc2;
      r_inst_mem[w_tail_nxt_slot] <= f_inst2;
    end
  end

  // NOTE: state registers use non-blocking assignments so every reader in
  // this edge sees the pre-edge values of head, tail and count.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_n);
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(2);
      end
      r_count <= r_count + w_push_n - w_pop_n;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_buffer;

  localparam int DEPTH = 8;
  localparam int PC_W  = 13;

  logic              CLK;
  logic              NRST;
  logic              f_valid;
  logic [PC_W-1:0]   f_pc1;
  logic [PC_W-1:0]   f_pc2;
  logic [31:0]       f_inst1;
  logic [31:0]       f_inst2;
  logic              stall;
  logic              flush;
  logic              d_ready;
  logic              i_valid1;
  logic              i_valid2;
  logic [PC_W-1:0]   i_pc1;
  logic [PC_W-1:0]   i_pc2;
  logic [31:0]       i_inst1;
  logic [31:0]       i_inst2;

  fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK      (CLK),
    .NRST     (NRST),
    .f_valid  (f_valid),
    .f_pc1    (f_pc1),
    .f_pc2    (f_pc2),
    .f_inst1  (f_inst1),
    .f_inst2  (f_inst2),
    .stall    (stall),
    .flush    (flush),
    .d_ready  (d_ready),
    .i_valid1 (i_valid1),
    .i_valid2 (i_valid2),
    .i_pc1    (i_pc1),
    .i_pc2    (i_pc2),
    .i_inst1  (i_inst1),
    .i_inst2  (i_inst2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } ent_t;

  ent_t q[$];
  int   issued[$];
  bit   rec_en = 1'b0;

  // Second slot must wait if the first redirects or the second consumes the first's result.
  function automatic bit hold_m(input logic [31:0] a, input logic [31:0] b);
    logic [6:0] op_a;
    logic [6:0] op_b;
    logic [4:0] rd;
    op_a = a[6:0];
    op_b = b[6:0];
    rd   = a[11:7];
    if (op_a == 7'h63 || op_a == 7'h6f || op_a == 7'h67) return 1'b1;
    if (op_a == 7'h23) return 1'b0;
    if (rd == 5'd0) return 1'b0;
    if (!(op_b == 7'h37 || op_b == 7'h17 || op_b == 7'h6f) && b[19:15] == rd) return 1'b1;
    if ((op_b == 7'h33 || op_b == 7'h23 || op_b == 7'h63) && b[24:20] == rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_issue_n(input bit with_flush);
    if (with_flush || q.size() == 0) return 0;
    if (q.size() == 1) return 1;
    return hold_m(q[0].inst, q[1].inst) ? 1 : 2;
  endfunction

  always @(negedge NRST) q.delete();

  always @(posedge CLK) begin
    if (NRST) begin
      bit full_e;
      int n;
      full_e = (q.size() > DEPTH - 2);
      n      = exp_issue_n(flush);
      if (flush) begin
        q.delete();
      end else begin
        if (d_ready) begin
          for (int i = 0; i < n; i++) void'(q.pop_front());
        end
        if (f_valid && !full_e) begin
          q.push_back('{pc: f_pc1, inst: f_inst1});
          q.push_back('{pc: f_pc2, inst: f_inst2});
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!NRST) begin
      check("rst_stall", stall, 0);
      check("rst_v1", i_valid1, 0);
      check("rst_v2", i_valid2, 0);
    end else begin
      int n;
      n = exp_issue_n(flush);
      check("cyc_stall", stall, (q.size() > DEPTH - 2));
      check("cyc_v1", i_valid1, (n >= 1));
      check("cyc_v2", i_valid2, (n == 2));
      if (n >= 1) begin
        check("cyc_pc1", i_pc1, q[0].pc);
        check("cyc_inst1", i_inst1, q[0].inst);
      end
      if (n == 2) begin
        check("cyc_pc2", i_pc2, q[1].pc);
        check("cyc_inst2", i_inst2, q[1].inst);
      end
      if (rec_en && d_ready && i_valid1) issued.push_back(int'(i_pc1));
      if (rec_en && d_ready && i_valid2) issued.push_back(int'(i_pc2));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
  endfunction

  function automatic logic [31:0] enc_beq(input int rs1, input int rs2);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | 32'h63;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_grp(input int pc, input logic [31:0] a, input logic [31:0] b);
    f_valid = 1'b1;
    f_pc1   = PC_W'(pc);
    f_pc2   = PC_W'(pc + 1);
    f_inst1 = a;
    f_inst2 = b;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pc;
    int cyc;
    bit acc;

    NRST = 1'b0; f_valid = 1'b0; flush = 1'b0; d_ready = 1'b0;
    f_pc1 = '0; f_pc2 = '0; f_inst1 = '0; f_inst2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_v1", i_valid1, 0);
    check("reset_stall", stall, 0);
    @(negedge CLK);
    NRST = 1'b1;

    // Fill to stall: four independent ADDI pairs, decode not ready.
    for (int k = 0; k < 4; k++) begin
      if (k == 0) set_grp(0, enc_addi(1, 0, 1), enc_addi(2, 0, 2));
      else        set_grp(2 * k, enc_addi(2 * k + 1, 0, k), enc_addi(2 * k + 2, 0, k));
      step();
      if (k == 2) begin
        @(negedge CLK);
        check("six_no_stall", stall, 0);
      end
    end
    set_grp(8, enc_addi(9, 0, 9), enc_addi(10, 0, 10));
    @(negedge CLK);
    check("fill_stall", stall, 1);
    check("fill_model_count", q.size(), 8);
    step();
    @(negedge CLK);
    check("held_stall", stall, 1);
    check("held_model_count", q.size(), 8);

    // Dual issue from the full buffer.
    f_valid = 1'b0;
    d_ready = 1'b1;
    #1;
    check("dual_v1", i_valid1, 1);
    check("dual_v2", i_valid2, 1);
    check("dual_pc1", i_pc1, 0);
    check("dual_pc2", i_pc2, 1);
    step();
    @(negedge CLK);
    check("dual_stall_low", stall, 0);
    check("dual_model_count", q.size(), 6);

    // Flush with push and pop requested in the same cycle.
    flush = 1'b1;
    d_ready = 1'b1;
    set_grp(8, enc_addi(9, 0, 9), enc_addi(10, 0, 10));
    #1;
    check("flush_v1", i_valid1, 0);
    check("flush_v2", i_valid2, 0);
    step();
    flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
    @(negedge CLK);
    check("post_flush_v1", i_valid1, 0);
    check("post_flush_stall", stall, 0);

    // RAW hold.
    set_grp(0, enc_addi(5, 0, 1), enc_add(6, 5, 5));
    step();
    f_valid = 1'b0;
    d_ready = 1'b1;
    #1;
    check("raw_v1", i_valid1, 1);
    check("raw_v2", i_valid2, 0);
    check("raw_pc1", i_pc1, 0);
    step();
    check("raw_next_v1", i_valid1, 1);
    check("raw_next_pc1", i_pc1, 1);
    check("raw_next_v2", i_valid2, 0);
    step();
    check("raw_empty", i_valid1, 0);
    d_ready = 1'b0;

    // Branch hold, then an x0 writer feeding an x0 reader.
    set_grp(2, enc_beq(1, 2), enc_addi(3, 0, 3));
    step();
    f_valid = 1'b0;
    d_ready = 1'b1;
    #1;
    check("br_v2", i_valid2, 0);
    check("br_pc1", i_pc1, 2);
    check("br_inst1", i_inst1, 32'h00208063);
    step();
    check("br_next_pc1", i_pc1, 3);
    step();
    d_ready = 1'b0;
    set_grp(4, enc_addi(0, 0, 5), enc_add(7, 0, 0));
    step();
    f_valid = 1'b0;
    #1;
    check("x0_v2", i_valid2, 1);
    check("x0_pc2", i_pc2, 5);
    d_ready = 1'b1;
    step();
    check("x0_drained", i_valid1, 0);
    d_ready = 1'b0;

    // Wrap: reset, then stream 20 pairs with random decode readiness.
    NRST = 1'b0;
    @(negedge CLK);
    NRST = 1'b1;
    rec_en = 1'b1;
    pc = 0;
    cyc = 0;
    while (pc < 40 && cyc < 1000) begin
      case ((pc / 2) % 3)
        0:       set_grp(pc, enc_addi(5, 0, pc), enc_add(6, 5, 5));
        1:       set_grp(pc, enc_beq(1, 2), enc_addi(3, 0, pc));
        default: set_grp(pc, enc_addi(7, 0, pc), enc_addi(8, 0, pc));
      endcase
      d_ready = 1'($urandom_range(0, 1));
      acc = !stall;
      @(posedge CLK);
      #1;
      if (acc) pc += 2;
      cyc++;
    end
    check("wrap_all_pushed", pc, 40);
    f_valid = 1'b0;
    d_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      step();
      cyc++;
    end
    @(negedge CLK);
    rec_en = 1'b0;
    check("wrap_drained", q.size(), 0);
    check("wrap_issue_len", issued.size(), 40);
    for (int i = 0; i < issued.size() && i < 40; i++) check("wrap_seq", issued[i], i);

    // Asynchronous reset mid-stream.
    d_ready = 1'b0;
    set_grp(100, enc_addi(1, 0, 1), enc_addi(2, 0, 2));
    step();
    step();
    f_valid = 1'b0;
    #2;
    NRST = 1'b0;
    #1;
    check("async_stall", stall, 0);
    check("async_v1", i_valid1, 0);
    check("async_v2", i_valid2, 0);
    @(negedge CLK);
    NRST = 1'b1;
    set_grp(200, enc_addi(1, 0, 1), enc_addi(2, 0, 2));
    step();
    f_valid = 1'b0;
    #1;
    check("after_rst_v1", i_valid1, 1);
    check("after_rst_pc1", i_pc1, 200);
    check("after_rst_v2", i_valid2, 1);
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction buffer between the dual-fetch stage and decode. Each cycle it accepts up to two instructions with their PCs and issues up to two in program order. It holds the second instruction back when it depends on the first or when the first is a control-transfer. It drives `stall` back to fetch when full, and it empties on a misprediction flush.

## Interface
- `DEPTH`, 8, number of buffer entries; power of two, at least 4.
- `PC_W`, 13, PC width; word address into instruction memory.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `NRST`  in  1  asynchronous, active-low reset.
- `f_valid`  in  1  fetch group present.
- `f_pc1`, `f_pc2`  in  PC_W  PCs of the fetch pair; `f_pc2 = f_pc1 + 1`.
- `f_inst1`, `f_inst2`  in  32  instruction words of the pair.
- `stall`  out  1  fetch must hold its PC; the group is not accepted.
- `flush`  in  1  branch mispredict; discard all contents.
- `d_ready`  in  1  decode accepts an issue this cycle.
- `i_valid1`, `i_valid2`  out  1  issue slot valid; `i_valid2` implies `i_valid1`.
- `i_pc1`, `i_pc2`  out  PC_W  PCs of the issued instructions.
- `i_inst1`, `i_inst2`  out  32  issued instruction words.

## Operation
- **Storage:** circular buffer with `DEPTH` entries of {pc, inst}, a head pointer, a tail pointer and a count.
  - Pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
  - The count is `log2(DEPTH)+1` bits.
- **Push:** when `f_valid & ~stall & ~flush`, write the pair into entries tail and tail+1 (wrapping), then tail += 2.
- **Stall:** `stall = (count > DEPTH-2)`.
  - Computed combinationally from registered count only.
  - Same-cycle pops are ignored.
- **Issue outputs** are combinational from the head entries:
  - `i_valid1 = (count >= 1) & ~flush`.
  - `i_valid2 = (count >= 2) & ~flush & ~hold`.
- **Pop:** when `d_ready`, the number popped is `i_valid1 + i_valid2`. Slots not popped remain and are re-presented in the next cycle.
- **hold** is true when either of the following holds:
  - Inst1 is a control transfer: BRANCH 1100011, JAL 1101111 or JALR 1100111.
  - There is a RAW dependency: inst1 writes rd, rd ≠ 0, and inst2 reads rd.
- **Writes rd:** every opcode except STORE 0100011 and BRANCH 1100011.
- **Reads rs1:** every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
- **Reads rs2:** OP 0110011, STORE and BRANCH.
- **Count update:** next count = count + pushed − popped.
  - Push and pop in the same cycle are legal.
  - Count never exceeds `DEPTH` and never goes below 0.
- **Flush:** on the next edge, count, head and tail go to 0.
  - A fetch group presented in the flush cycle is dropped.
  - Nothing issues in the flush cycle.
- **Reset (NRST low):** head = tail = count = 0.
  - `stall`, `i_valid1` and `i_valid2` are 0 immediately, asynchronously.
  - Entry contents are don't-care.

## Timing
- **Push-to-issue latency:** a group accepted at edge N is visible on the issue outputs in cycle N+1. There is no combinational bypass from `f_*` to `i_*`.
- **Stall timing:** `stall` rises in the cycle after the count reaches `DEPTH-1` or `DEPTH`. While `stall` is high, fetch re-presents the same group and it is accepted on the first cycle in which `stall` is low.
- **Full:** with count = `DEPTH`, `stall` = 1. A pop in that cycle lowers `stall` in the next cycle.
- **Empty:** with count = 0, both issue-valid signals are 0 and `d_ready` has no effect.
- **Single entry:** with count = 1, only slot 1 issues.
- **Wrap:** entry `DEPTH-1` followed by entry 0 issues as a normal pair.
- **Flush vs. push/pop:** flush dominates push and pop in the same cycle.
- **Reset mid-operation:** discards all contents asynchronously. The first push is accepted in the first cycle after NRST is high.

## Structure
- **Shared package:** RV32I opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) and field-slice positions (rd [11:7], rs1 [19:15], rs2 [24:20], opcode [6:0]). Decode and the future issue logic reuse these.
- **Sub-module `dep_check`:** purely combinational. Takes two 32-bit instructions and returns `hold`.

## Test plan
- **Fill to stall:** reset, `d_ready` = 0, push 4 pairs of independent ADDI at PCs 0–7 → count = 8, `stall` = 1 from the cycle after the 4th push, the 5th group is held.
- **Dual issue:** `ADDI x1,x0,1` + `ADDI x2,x0,2`, `d_ready` = 1 → both slots valid with PCs 0 and 1; count drops by 2.
- **RAW hold:** `ADDI x5,x0,1` + `ADD x6,x5,x5` → only slot 1 issues (PC 0). The next cycle issues the ADD as slot 1 (PC 1).
- **Branch hold:** BEQ + ADDI → the BEQ issues alone. Separately, `rd` = x0 followed by a reader of x0 → both issue.
- **Flush:** count = 6, assert `flush` together with `f_valid` and `d_ready` → no issue that cycle, count = 0 the next cycle, `stall` = 0, the dropped group is not stored.
- **Wrap and reset:** cycle 20 pairs through with random `d_ready` → issued PC sequence is 0..39 with no gaps or duplicates. Assert NRST low mid-stream → outputs go low immediately and count = 0.
